// File: rtl/spw_tx_encoder.sv
// SpaceWire transmit encoder: per-character arbitration, parity insertion and
// Data-Strobe serialization, plus TX credit and outgoing FCT bookkeeping.
module spw_tx_encoder #(
  parameter int TX_CLK_DIV   = 1,
  parameter int MAX_CREDIT   = 56,
  parameter int MAX_FCT_PEND = 7
) (
  input  logic       tx_clk,
  input  logic       tx_reset,
  input  logic       enable_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       gotfct_tx,
  input  logic       send_fct_now,
  input  logic       tickin_tx,
  input  logic [7:0] time_in,
  input  logic       txwrite_tx,
  input  logic [8:0] txdata_flagctrl_tx,
  output logic       ready_tx,
  output logic       fct_sent,
  output logic       credit_error_tx,
  output logic [5:0] tx_credit,
  output logic       dout,
  output logic       sout
);

  localparam int BW = (TX_CLK_DIV > 0) ? $clog2(TX_CLK_DIV + 1) : 1;
  localparam int PW = $clog2(MAX_FCT_PEND + 1);

  typedef enum logic [2:0] {CH_NONE, CH_TIME, CH_FCT, CH_NCHAR, CH_NULL} ch_t;

  logic [BW-1:0] r_bcnt;
  logic [13:0]   r_shift;
  logic [3:0]    r_left;
  logic          r_par;
  logic          r_dout, r_sout;
  logic [5:0]    r_credit;
  logic          r_cerr;
  logic [PW-1:0] r_fpend;
  logic          r_tick;
  logic [7:0]    r_time;

  ch_t         w_sel;
  logic [13:0] w_code;
  logic [3:0]  w_len;
  logic        w_par_nxt;
  logic        w_bound, w_arb, w_drive, w_bit;
  logic        w_nload, w_fload, w_finc, w_gf_ok;

  assign w_bound = enable_tx & (r_bcnt == '0);
  // Arbitrate while the last bit goes out so the next character follows with no gap.
  assign w_arb   = w_bound & (r_left <= 4'd1);

  always_comb begin
    w_sel = CH_NONE;
    if (w_arb) begin
      if (r_tick & send_fct_tx)                                     w_sel = CH_TIME;
      else if ((r_fpend != '0) & send_fct_tx)                       w_sel = CH_FCT;
      else if (txwrite_tx & send_fct_tx & (r_credit != 6'd0))       w_sel = CH_NCHAR;
      else if (send_null_tx | send_fct_tx)                          w_sel = CH_NULL;
    end
  end

  // Codes are LSB-first; bit 0 is the parity bit computed from the previous character.
  always_comb begin
    w_code    = '0;
    w_len     = 4'd0;
    w_par_nxt = r_par;
    case (w_sel)
      CH_TIME: begin
        w_code    = {r_time, 1'b0, 1'b1, 3'b111, r_par};
        w_len     = 4'd14;
        w_par_nxt = ^r_time;
      end
      CH_FCT: begin
        w_code    = {10'd0, 3'b001, r_par};
        w_len     = 4'd4;
        w_par_nxt = 1'b0;
      end
      CH_NCHAR: begin
        if (txdata_flagctrl_tx[8]) begin
          w_code    = {10'd0, ~txdata_flagctrl_tx[0], txdata_flagctrl_tx[0], 1'b1, r_par};
          w_len     = 4'd4;
          w_par_nxt = 1'b1;
        end else begin
          w_code    = {4'd0, txdata_flagctrl_tx[7:0], 1'b0, ~r_par};
          w_len     = 4'd10;
          w_par_nxt = ^txdata_flagctrl_tx[7:0];
        end
      end
      CH_NULL: begin
        w_code    = {6'd0, 4'b0010, 3'b111, r_par};
        w_len     = 4'd8;
        w_par_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_drive = w_bound & ((r_left != 4'd0) | (w_sel != CH_NONE));
  assign w_bit   = (r_left != 4'd0) ? r_shift[0] : w_code[0];
  assign w_nload = (w_sel == CH_NCHAR);
  assign w_fload = (w_sel == CH_FCT);
  assign w_finc  = send_fct_now & ((r_fpend < PW'(MAX_FCT_PEND)) | w_fload);
  assign w_gf_ok = gotfct_tx & (({1'b0, r_credit} + 7'd8) <= 7'(MAX_CREDIT));

  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_left   <= '0;
      r_par    <= 1'b0;
      r_dout   <= 1'b0;
      r_sout   <= 1'b0;
      r_credit <= '0;
      r_cerr   <= 1'b0;
      r_fpend  <= '0;
      r_tick   <= 1'b0;
      r_time   <= '0;
    end else if (!enable_tx) begin
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_left   <= '0;
      r_par    <= 1'b0;
      r_dout   <= 1'b0;
      r_sout   <= 1'b0;
      r_credit <= '0;
      r_cerr   <= 1'b0;
      r_fpend  <= '0;
      r_tick   <= 1'b0;
      r_time   <= '0;
    end else begin
      r_bcnt <= (r_bcnt == '0) ? BW'(TX_CLK_DIV) : r_bcnt - 1'b1;
      if (w_bound) begin
        if (r_left > 4'd1) begin
          r_shift <= r_shift >> 1;
          r_left  <= r_left - 4'd1;
        end else if (r_left == 4'd1) begin
          r_shift <= w_code;
          r_left  <= w_len;
        end else if (w_sel != CH_NONE) begin
          r_shift <= w_code >> 1;
          r_left  <= w_len - 4'd1;
        end
        if (w_sel != CH_NONE) r_par <= w_par_nxt;
      end
      if (w_drive) begin
        r_dout <= w_bit;
        r_sout <= r_sout ^ ~(w_bit ^ r_dout);
      end
      r_credit <= r_credit + (w_gf_ok ? 6'd8 : 6'd0) - {5'd0, w_nload};
      if (gotfct_tx & ~w_gf_ok) r_cerr <= 1'b1;
      r_fpend <= r_fpend + PW'(w_finc) - PW'(w_fload);
      if (tickin_tx) begin
        r_tick <= 1'b1;
        r_time <= time_in;
      end else if (w_sel == CH_TIME) begin
        r_tick <= 1'b0;
      end
    end
  end

  assign ready_tx        = w_nload;
  assign fct_sent        = w_fload;
  assign credit_error_tx = r_cerr;
  assign tx_credit       = r_credit;
  assign dout            = r_dout;
  assign sout            = r_sout;

endmodule
